axis_fifo_ctrl: RTL

Sequencing controller for the AXIS data FIFO memory. It owns the write and read pointers, the occupancy count and the full/empty/almost flags, and it drives the memory's write port, read address and full/empty inputs. It presents an AXI-Stream slave on the input side and a registered AXI-Stream master on the output side. It sits between the upstream AXIS source and the downstream sink, with the dual-port FIFO memory instantiated alongside and wired only to this block.

---
 rtl/axis_fifo_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/axis_fifo_ctrl.sv
// Sequencing controller for the AXIS data FIFO: owns pointers, occupancy and flags,
// and drives a registered AXI-Stream output stage fed from an external dual-port memory.
module axis_fifo_ctrl #(
   parameter int  FIFO_DEPTH      = 16,
   parameter int  FIFO_WIDTH      = 32,
   parameter int  ALMOST_FULL_TH  = 12,
   parameter int  ALMOST_EMPTY_TH = 2,
   localparam int AW              = $clog2(FIFO_DEPTH)
) (
   input  logic                  wr_clk,
   input  logic                  rst,
   input  logic [FIFO_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [FIFO_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  mem_w_en,
   output logic [AW-1:0]         mem_w_addr,
   output logic [FIFO_WIDTH-1:0] mem_w_data,
   output logic [AW-1:0]         mem_r_addr,
   input  logic [FIFO_WIDTH-1:0] mem_r_data,
   output logic                  mem_full,
   output logic                  mem_empty,
   output logic [AW:0]           count,
   output logic                  almost_full,
   output logic                  almost_empty
);

   localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] AF_TH_C = (AW+1)'(ALMOST_FULL_TH);
   localparam logic [AW:0] AE_TH_C = (AW+1)'(ALMOST_EMPTY_TH);

   logic [AW:0]           wr_ptr_r;
   logic [AW:0]           rd_ptr_r;
   logic [AW:0]           count_r;
   logic [FIFO_WIDTH-1:0] tdata_r;
   logic                  tvalid_r;

   logic                  full_s;
   logic                  empty_s;
   logic                  push_s;
   logic                  load_s;
   logic [AW:0]           count_nxt_s;

   // Flag decode from registered pointers, handshake qualification and next occupancy.
   always_comb begin
      full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
      empty_s     = (wr_ptr_r == rd_ptr_r);
      push_s      = s_axis_tvalid && !full_s;
      // The output register refills whenever it is empty or being drained this cycle.
      load_s      = !empty_s && (!tvalid_r || m_axis_tready);
      count_nxt_s = count_r;
      case ({push_s, load_s})
         2'b10:   count_nxt_s = count_r + ONE_C;
         2'b01:   count_nxt_s = count_r - ONE_C;
         default: count_nxt_s = count_r;
      endcase
   end

   // Pointer and occupancy state; pointers carry a wrap bit above the address bits.
   always_ff @(posedge wr_clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + ONE_C;
         end
         if (load_s) begin
            rd_ptr_r <= rd_ptr_r + ONE_C;
         end
         count_r <= count_nxt_s;
      end
   end

   // Output stage; data holds whenever the register is not reloaded.
   always_ff @(posedge wr_clk or posedge rst) begin
      if (rst) begin
         tdata_r  <= {FIFO_WIDTH{1'b0}};
         tvalid_r <= 1'b0;
      end else if (load_s) begin
         tdata_r  <= mem_r_data;
         tvalid_r <= 1'b1;
      end else if (tvalid_r && m_axis_tready) begin
         tvalid_r <= 1'b0;
      end else begin
         tvalid_r <= tvalid_r;
      end
   end

   assign s_axis_tready = !full_s;
   assign m_axis_tdata  = tdata_r;
   assign m_axis_tvalid = tvalid_r;
   assign mem_w_en      = push_s;
   assign mem_w_addr    = wr_ptr_r[AW-1:0];
   assign mem_w_data    = s_axis_tdata;
   assign mem_r_addr    = rd_ptr_r[AW-1:0];
   assign mem_full      = full_s;
   assign mem_empty     = empty_s;
   assign count         = count_r;
   assign almost_full   = (count_r >= AF_TH_C);
   assign almost_empty  = (count_r <= AE_TH_C);

endmodule
